// File: rtl/gb_cpu_interrupt_controller.sv
// Game Boy CPU interrupt controller: IE/IF registers, IME, and IDLE->QUEUED->SERVICE dispatch.
// Optional GB_CPU_EI_DELAY_EN delays IME set after EI by one instruction.
module gb_cpu_interrupt_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] irq_i,
    input  logic       ie_wren,
    input  logic       if_wren,
    input  logic [7:0] reg_wdata,
    input  logic       enable_interrupts,
    input  logic       disable_interrupts,
    input  logic       instr_boundary,
    input  logic       write_interrupt_vector,
    input  logic       clear_interrupt_flag,
    output logic       interrupt_queued,
    output logic [7:0] int_vector,
    output logic [7:0] ie_o,
    output logic [7:0] if_o,
    output logic       ime_o,
    output logic       wake_o
);

    typedef enum logic [1:0] {IDLE, QUEUED, SERVICE} state_t;

    state_t     state_q, state_d;
    logic [4:0] irq_prev_q, irq_prev_d;
    logic [7:0] ie_q, ie_d;
    logic [4:0] if_q, if_d;
    logic       ime_q, ime_d;
    logic       queued_q, queued_d;
    logic [7:0] vec_q, vec_d;
    logic [2:0] idx_q, idx_d;
    logic       idx_vld_q, idx_vld_d;
`ifdef GB_CPU_EI_DELAY_EN
    logic       ei_pend_q, ei_pend_d;
`endif

    logic [4:0] pending;
    logic [2:0] low_idx;
    logic       ack;

    assign pending = ie_q[4:0] & if_q[4:0];
    assign ack     = (state_q == SERVICE) && clear_interrupt_flag;

    always_comb begin
        low_idx = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (pending[i]) low_idx = 3'(i);
    end

    always_comb begin
        irq_prev_d = irq_i;
        ie_d       = ie_wren ? reg_wdata : ie_q;

        // Software/ack clears first, then hardware edges so a new request always wins.
        if_d = if_wren ? reg_wdata[4:0] : if_q;
        if (ack && idx_vld_q) if_d[idx_q] = 1'b0;
        if_d = if_d | (irq_i & ~irq_prev_q);

        ime_d = ime_q;
`ifdef GB_CPU_EI_DELAY_EN
        ei_pend_d = ei_pend_q;
        if (ei_pend_q && instr_boundary) begin
            ime_d     = 1'b1;
            ei_pend_d = 1'b0;
        end
        if (enable_interrupts) ei_pend_d = 1'b1;
`else
        if (enable_interrupts) ime_d = 1'b1;
`endif
        if (ack) ime_d = 1'b0;
        if (disable_interrupts) begin
            ime_d = 1'b0;
`ifdef GB_CPU_EI_DELAY_EN
            ei_pend_d = 1'b0;
`endif
        end

        state_d   = state_q;
        queued_d  = queued_q;
        vec_d     = vec_q;
        idx_d     = idx_q;
        idx_vld_d = idx_vld_q;
        case (state_q)
            IDLE: if (instr_boundary && ime_q && (|pending)) begin
                state_d  = QUEUED;
                queued_d = 1'b1;
            end
            QUEUED: if (write_interrupt_vector) begin
                state_d   = SERVICE;
                idx_d     = low_idx;
                idx_vld_d = |pending;
                vec_d     = (|pending) ? (8'h40 + {2'b00, low_idx, 3'b000}) : 8'h00;
            end
            SERVICE: if (clear_interrupt_flag) begin
                state_d  = IDLE;
                queued_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            irq_prev_q <= 5'd0;
            ie_q       <= 8'h00;
            if_q       <= 5'd0;
            ime_q      <= 1'b0;
            queued_q   <= 1'b0;
            vec_q      <= 8'h00;
            idx_q      <= 3'd0;
            idx_vld_q  <= 1'b0;
`ifdef GB_CPU_EI_DELAY_EN
            ei_pend_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            ie_q       <= ie_d;
            if_q       <= if_d;
            ime_q      <= ime_d;
            queued_q   <= queued_d;
            vec_q      <= vec_d;
            idx_q      <= idx_d;
            idx_vld_q  <= idx_vld_d;
`ifdef GB_CPU_EI_DELAY_EN
            ei_pend_q  <= ei_pend_d;
`endif
        end
    end

    assign interrupt_queued = queued_q;
    assign int_vector       = vec_q;
    assign ie_o             = ie_q;
    assign if_o             = {3'b111, if_q};
    assign ime_o            = ime_q;
    assign wake_o           = |pending;

endmodule

// File: tb/tb_gb_cpu_interrupt_controller.sv
// Directed bench for gb_cpu_interrupt_controller; expectations hand-computed per scenario.
module tb_gb_cpu_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] irq_i = '0;
    logic       ie_wren = 0, if_wren = 0;
    logic [7:0] reg_wdata = '0;
    logic       enable_interrupts = 0, disable_interrupts = 0;
    logic       instr_boundary = 0, write_interrupt_vector = 0, clear_interrupt_flag = 0;
    logic       interrupt_queued, ime_o, wake_o;
    logic [7:0] int_vector, ie_o, if_o;

    int n_cmp = 0;
    int n_err = 0;

    gb_cpu_interrupt_controller dut (
        .clk(clk), .reset(reset), .irq_i(irq_i), .ie_wren(ie_wren), .if_wren(if_wren),
        .reg_wdata(reg_wdata), .enable_interrupts(enable_interrupts),
        .disable_interrupts(disable_interrupts), .instr_boundary(instr_boundary),
        .write_interrupt_vector(write_interrupt_vector), .clear_interrupt_flag(clear_interrupt_flag),
        .interrupt_queued(interrupt_queued), .int_vector(int_vector), .ie_o(ie_o),
        .if_o(if_o), .ime_o(ime_o), .wake_o(wake_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h want 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_ie(input logic [7:0] d);
        ie_wren = 1; reg_wdata = d; cyc(); ie_wren = 0;
    endtask

    task automatic wr_if(input logic [7:0] d);
        if_wren = 1; reg_wdata = d; cyc(); if_wren = 0;
    endtask

    task automatic ei();
        enable_interrupts = 1; cyc(); enable_interrupts = 0;
    endtask

    task automatic bnd();
        instr_boundary = 1; cyc(); instr_boundary = 0;
    endtask

    task automatic wv();
        write_interrupt_vector = 1; cyc(); write_interrupt_vector = 0;
    endtask

    task automatic clr();
        clear_interrupt_flag = 1; cyc(); clear_interrupt_flag = 0;
    endtask

    initial begin
        // reset state
        cyc(); cyc();
        chk("rst_ie", ie_o, 8'h00);
        chk("rst_if", if_o, 8'hE0);
        chk("rst_ime", {7'd0, ime_o}, 8'h00);
        chk("rst_wake", {7'd0, wake_o}, 8'h00);
        chk("rst_q", {7'd0, interrupt_queued}, 8'h00);
        chk("rst_vec", int_vector, 8'h00);
        @(negedge clk); reset = 0;
        cyc();

        // timer interrupt end to end
        wr_ie(8'h04);
        ei(); bnd();
        chk("t_ime", {7'd0, ime_o}, 8'h01);
        irq_i[2] = 1; cyc();
        chk("t_if", if_o, 8'hE4);
        chk("t_wake", {7'd0, wake_o}, 8'h01);
        chk("t_noq", {7'd0, interrupt_queued}, 8'h00);
        bnd();
        chk("t_q", {7'd0, interrupt_queued}, 8'h01);
        cyc();
        wv();
        chk("t_vec", int_vector, 8'h50);
        clr();
        chk("t_if_ack", if_o, 8'hE0);
        chk("t_ime_ack", {7'd0, ime_o}, 8'h00);
        chk("t_q_ack", {7'd0, interrupt_queued}, 8'h00);
        chk("t_vec_hold", int_vector, 8'h50);
        irq_i = '0; cyc();

        // priority: STAT beats Serial
        ei(); bnd();
        wr_ie(8'h1F);
        wr_if(8'h0A);
        chk("p_if", if_o, 8'hEA);
        bnd();
        chk("p_q", {7'd0, interrupt_queued}, 8'h01);
        wv();
        chk("p_vec", int_vector, 8'h48);
        clr();
        chk("p_if_ack", if_o, 8'hE8);
        // vector write and ack ignored in IDLE
        wv();
        chk("idle_vec", int_vector, 8'h48);
        clr();
        chk("idle_if", if_o, 8'hE8);
        wr_if(8'h00);

        // request withdrawn by IE write while queued
        wr_ie(8'h01);
        ei(); bnd();
        wr_if(8'h01);
        bnd();
        chk("w_q", {7'd0, interrupt_queued}, 8'h01);
        wr_ie(8'h00);
        wv();
        chk("w_vec", int_vector, 8'h00);
        clr();
        chk("w_if", if_o, 8'hE1);
        chk("w_q_ack", {7'd0, interrupt_queued}, 8'h00);

        // EI latency with VBlank already pending
        wr_ie(8'h01);
        ei();
        bnd();
        chk("ei_ime", {7'd0, ime_o}, 8'h01);
`ifdef GB_CPU_EI_DELAY_EN
        chk("ei_noq", {7'd0, interrupt_queued}, 8'h00);
        bnd();
`endif
        chk("ei_q", {7'd0, interrupt_queued}, 8'h01);
        wv();
        chk("ei_vec", int_vector, 8'h40);
        clr();
        chk("ei_if", if_o, 8'hE0);
        // EI and DI together: DI wins
        enable_interrupts = 1; disable_interrupts = 1; cyc();
        enable_interrupts = 0; disable_interrupts = 0;
        bnd(); bnd();
        chk("eidi_ime", {7'd0, ime_o}, 8'h00);

        // hardware set beats software clear
        if_wren = 1; reg_wdata = 8'h00; irq_i[4] = 1; cyc(); if_wren = 0;
        chk("hw_pri_if", if_o, 8'hF0);

        // async reset while in SERVICE
        wr_ie(8'h10);
        ei(); bnd(); bnd();
        chk("r_q", {7'd0, interrupt_queued}, 8'h01);
        wv();
        chk("r_vec", int_vector, 8'h60);
        #2 reset = 1; #1;
        chk("ar_q", {7'd0, interrupt_queued}, 8'h00);
        chk("ar_vec", int_vector, 8'h00);
        chk("ar_ie", ie_o, 8'h00);
        chk("ar_if", if_o, 8'hE0);
        chk("ar_ime", {7'd0, ime_o}, 8'h00);
        chk("ar_wake", {7'd0, wake_o}, 8'h00);
        irq_i = '0;
        cyc();
        @(negedge clk); reset = 0;
        cyc();
        chk("post_if", if_o, 8'hE0);
        chk("post_q", {7'd0, interrupt_queued}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gb_cpu_interrupt_controller.md
GB_CPU_INTERRUPT_CONTROLLER -- requirements
Module: gb_cpu_interrupt_controller

Interface
REQ-001 SHALL have port clk, input, 1, machine (M) clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, system reset; asynchronous, active-high.
REQ-003 SHALL have port irq_i, input, 5, interrupt request lines: bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
REQ-004 SHALL have port ie_wren, input, 1, write reg_wdata into IE this cycle.
REQ-005 SHALL have port if_wren, input, 1, write reg_wdata into IF this cycle.
REQ-006 SHALL have port reg_wdata, input, 8, CPU write data for IE/IF.
REQ-007 SHALL have port enable_interrupts, input, 1, EI executed this M-cycle.
REQ-008 SHALL have port disable_interrupts, input, 1, DI executed this M-cycle.
REQ-009 SHALL have port instr_boundary, input, 1, high in the final M-cycle of each instruction (next cycle is a fetch or ISR start).
REQ-010 SHALL have port write_interrupt_vector, input, 1, ISR stage that latches the vector.
REQ-011 SHALL have port clear_interrupt_flag, input, 1, ISR stage that acknowledges the serviced interrupt.
REQ-012 SHALL have port interrupt_queued, output, 1, next instruction is the ISR.
REQ-013 SHALL have port int_vector, output, 8, low byte of ISR target address (high byte 0x00).
REQ-014 SHALL have port ie_o, output, 8, IE readback.
REQ-015 SHALL have port if_o, output, 8, IF readback; bits 7:5 read 1.
REQ-016 SHALL have port ime_o, output, 1, interrupt master enable.
REQ-017 SHALL have port wake_o, output, 1, combinational |(IE[4:0] & IF[4:0]), independent of IME (HALT exit).

Function
REQ-018 SHALL set IF[n] on the cycle following a rising edge of irq_i[n] (registered previous-value edge detect).
REQ-019 SHALL give hardware IF set priority over an if_wren clear or an acknowledge clear of the same bit in the same cycle.
REQ-020 SHALL store all 8 bits of IE on ie_wren; IF stores only reg_wdata[4:0] on if_wren.
REQ-021 SHALL clear IME and any pending EI on disable_interrupts; disable wins over a simultaneous enable_interrupts.
REQ-022 SHALL implement FSM IDLE, QUEUED, SERVICE.
REQ-023 IDLE->QUEUED on a cycle with instr_boundary=1, IME=1 and (IE[4:0]&IF[4:0])!=0; interrupt_queued registered, asserted from the next cycle.
REQ-024 QUEUED->SERVICE on write_interrupt_vector: latch index = lowest set bit of IE[4:0]&IF[4:0] at that cycle; int_vector = 0x40 + 8*index; if no bit is pending then, int_vector = 0x00 and no flag is cleared later.
REQ-025 SERVICE->IDLE on clear_interrupt_flag: clear IF[latched index], clear IME, deassert interrupt_queued the following cycle.
REQ-026 SHALL hold int_vector stable from write_interrupt_vector until the next write_interrupt_vector or reset.
REQ-027 SHALL ignore write_interrupt_vector in IDLE/SERVICE and clear_interrupt_flag in IDLE/QUEUED.
REQ-028 SHALL not queue while in QUEUED or SERVICE; a new pending request is evaluated at the first instr_boundary after returning to IDLE.

Reset
REQ-029 On reset (any time, including mid-dispatch): FSM=IDLE, IE=0x00, IF[4:0]=0, IME=0, EI pending=0, edge-detect history=0, interrupt_queued=0, int_vector=0x00.
REQ-030 ie_o=0x00, if_o=0xE0, ime_o=0, wake_o=0 during and immediately after reset.

Configuration
REQ-031 Macro GB_CPU_EI_DELAY_EN: when defined, enable_interrupts sets an EI-pending flag and IME becomes 1 at the end of the first instr_boundary cycle strictly after the EI cycle (one-instruction delay); that boundary does not itself queue.
REQ-032 When GB_CPU_EI_DELAY_EN is undefined, IME becomes 1 on the clock edge ending the enable_interrupts cycle; no EI-pending flag exists.

Verification
REQ-033 IE=0x04, IME=1, irq_i[2] rising -> IF=0xE4, next instr_boundary -> interrupt_queued=1; write_interrupt_vector -> int_vector=0x50; clear_interrupt_flag -> IF=0xE0, IME=0, queued=0.
REQ-034 IE=0x1F, IF set bits 1 and 3 together -> int_vector=0x48, IF=0xE8 after acknowledge.
REQ-035 IE=0x01, IF bit0 pending, IE written 0x00 in QUEUED before write_interrupt_vector -> int_vector=0x00, IF stays 0xE1.
REQ-036 With GB_CPU_EI_DELAY_EN: EI then one NOP with request pending -> no queue at NOP's boundary... at EI+1 instruction boundary queued; without macro -> queued at first boundary after EI; EI+DI same cycle -> IME=0 both builds.
REQ-037 irq_i[4] rising same cycle as if_wren with 0x00 -> IF=0xF0; reset asserted in SERVICE -> all outputs to REQ-029/030 values asynchronously.
